jt10_adpcma_rom_server: RTL and testbench
=========================================

// Module: jt10_adpcma_rom_server
// PURPOSE
//  Memory-side responder for the ADPCM-A ROM fetch interface: accepts {bank,addr,roe_n}
//  from the ADPCM-A driver and returns the addressed byte on adp_data before the next fetch slot.
//  Backs the six-channel fetch stream with a small fully-associative 16-bit word cache
//  in front of a req/ack SDRAM-style port. Sits between jt10 ADPCM-A and the core's memory arbiter.
// PARAMETERS
//  ENTRIES   6    cache entries (16-bit words), 2..8
//  MEM_AW    23   word address width (24-bit byte space {bank,addr} >> 1)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   asynchronous reset, active-low
//  cen6       in   1   driver fetch-slot enable (666 kHz)
//  adp_addr   in   20  byte address from driver
//  adp_bank   in   4   bank, upper address bits
//  adp_roe_n  in   1   fetch request, active-low
//  adp_data   out  8   returned ROM byte
//  mem_addr   out  MEM_AW  word address to arbiter
//  mem_req    out  1   request, held until mem_ack
//  mem_ack    in   1   request accepted (1 clk)
//  mem_dok    in   1   mem_dout valid (1 clk)
//  mem_dout   in   16  word read; byte0 = [7:0], byte1 = [15:8]
//  late_cnt   out  8   saturating count of fetch slots missed before fill
// BEHAVIOUR
//  - Reset: adp_data=0, mem_req=0, mem_addr=0, late_cnt=0, all cache valid bits cleared, FSM=IDLE.
//  - Byte address ba = {adp_bank,adp_addr}; word wa = ba[23:1]; lane = ba[0].
//  - Request capture: on cen6 with adp_roe_n=0, latch {wa,lane} into req register and set req_new.
//    roe_n=1 at cen6 → nothing captured; no memory traffic.
//  - FSM IDLE: on req_new → LOOKUP (next clk).
//  - LOOKUP: tag compare on all entries (1 clk). Hit → adp_data <= selected lane, → IDLE.
//    Hit latency: adp_data valid 2 clk after the capturing cen6.
//    Miss → mem_addr <= wa, mem_req <= 1, → REQ.
//  - REQ: hold mem_req/mem_addr stable until mem_ack; on mem_ack mem_req <= 0 → WAIT.
//    mem_ack and mem_dok in the same clk: treat as ack+fill, go straight to FILL.
//  - WAIT: on mem_dok → FILL with word latched.
//  - FILL: write word/tag into victim entry (round-robin pointer, advances per fill);
//    adp_data <= lane of fill word; → IDLE or LOOKUP if a pending request exists.
//  - Pending: a capture while FSM≠IDLE stores into a one-deep pending slot; a second capture
//    overwrites it (oldest dropped). Capture targeting the word being filled is served from fill data.
//  - Late: if a cen6 capture occurs while the previous request is still unserved (REQ/WAIT),
//    late_cnt += 1, saturating at 255. adp_data holds its last value until a fill/hit updates it.
//  - Duplicate tags never created: fill to a word already present (via pending race) overwrites
//    that entry instead of victim.
//  - Async reset mid-transaction: mem_req drops immediately; a later mem_ack/mem_dok in IDLE is ignored.
//  - Cache is read-only; no invalidation port (ROM contents static after load).
// STRUCTURE
//  - Shared defines (jt10_adpcm_defs include): FSM state encodings IDLE/LOOKUP/REQ/WAIT/FILL,
//    LANE_LO/LANE_HI, late counter width.
//  - Sub-module jt10_adpcma_rom_cache: tag/data/valid arrays, parallel compare, hit index,
//    round-robin victim pointer, write port. Top holds capture, pending slot, FSM, memory handshake.
// TESTING
//  1. Cold miss: bank 0, addr 0x00010 at cen6 → mem_req with mem_addr 0x000008; ack, dok 0xBEEF
//     → adp_data 0xEF 1 clk after FILL; next fetch addr 0x00011 → hit, adp_data 0xBE, no mem_req.
//  2. Bank/lane: bank 3, addr 0xFFFFF → mem_addr 0x1FFFFF, dout 0x12AB → adp_data 0x12.
//  3. Replacement: 7 distinct words filled in order → entry of word 1 evicted; refetch word 1 misses,
//     refetch word 2 hits.
//  4. Late: dok delayed 20 clk with cen6 every 6 clk → late_cnt = 3, adp_data unchanged until fill;
//     force 300 late slots → late_cnt saturates at 255.
//  5. Reset in WAIT: drop rst_n while mem_req=1 → mem_req=0, late_cnt=0; stray dok ignored;
//     next fetch of previously cached word misses.
//  6. roe_n held high across 100 cen6 → mem_req never asserted, adp_data stable.

Source files
------------

// File: rtl/jt10_adpcma_rom_server_pkg.sv
// Shared constants for the ADPCM-A ROM server: FSM encodings, byte-lane codes and counter width.
package jt10_adpcma_rom_server_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam int LATE_W = 8;

    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/jt10_adpcma_rom_cache.sv
// Fully-associative 16-bit word cache: parallel tag compare, round-robin victim, single write port.
module jt10_adpcma_rom_cache
    import jt10_adpcma_rom_server_pkg::*;
#(
    parameter int ENTRIES = 6,
    parameter int MEM_AW  = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MEM_AW-1:0] lk_addr,
    output logic              hit,
    output logic [15:0]       hit_data,
    input  logic              wr_en,
    input  logic [15:0]       wr_data
);
    localparam int IW = $clog2(ENTRIES);

    logic [MEM_AW-1:0]  tag  [ENTRIES];
    logic [15:0]        data [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [IW-1:0]      victim;
    logic [IW-1:0]      hit_idx;
    logic [IW-1:0]      wr_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && tag[i] == lk_addr) begin
                hit      = 1'b1;
                hit_idx  = IW'(i);
                hit_data = data[i];
            end
        end
    end

    // A word already present is rewritten in place so no duplicate tag can appear
    assign wr_idx = hit ? hit_idx : victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            victim <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                if (wr_idx == IW'(i)) valid[i] <= 1'b1;
            if (!hit)
                victim <= (victim == IW'(ENTRIES - 1)) ? '0 : victim + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (wr_idx == IW'(i)) begin
                    tag[i]  <= lk_addr;
                    data[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/jt10_adpcma_rom_server.sv
// ADPCM-A ROM responder: captures driver fetches, serves them from a word cache or a req/ack memory port.
module jt10_adpcma_rom_server
    import jt10_adpcma_rom_server_pkg::*;
#(
    parameter int ENTRIES = 6,
    parameter int MEM_AW  = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen6,
    input  logic [19:0]       adp_addr,
    input  logic [3:0]        adp_bank,
    input  logic              adp_roe_n,
    output logic [7:0]        adp_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic              mem_dok,
    input  logic [15:0]       mem_dout,
    output logic [LATE_W-1:0] late_cnt
);
    logic [2:0]        state;
    logic [23:0]       ba;
    logic              cap;
    logic [MEM_AW-1:0] cur_wa;
    logic              cur_lane;
    logic              req_new;
    logic              pend_valid;
    logic [MEM_AW-1:0] pend_wa;
    logic              pend_lane;
    logic [15:0]       fill_word;
    logic              hit;
    logic [15:0]       hit_data;

    assign ba  = {adp_bank, adp_addr};
    assign cap = cen6 & ~adp_roe_n;

    jt10_adpcma_rom_cache #(
        .ENTRIES (ENTRIES),
        .MEM_AW  (MEM_AW)
    ) u_cache (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk_addr  (cur_wa),
        .hit      (hit),
        .hit_data (hit_data),
        .wr_en    (state == S_FILL),
        .wr_data  (fill_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            adp_data   <= '0;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
            late_cnt   <= '0;
            cur_wa     <= '0;
            cur_lane   <= LANE_LO;
            req_new    <= 1'b0;
            pend_valid <= 1'b0;
            pend_wa    <= '0;
            pend_lane  <= LANE_LO;
            fill_word  <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_new) begin
                    req_new <= 1'b0;
                    state   <= S_LOOKUP;
                end
                S_LOOKUP: if (hit) begin
                    adp_data <= lane_byte(hit_data, cur_lane);
                    if (pend_valid) begin
                        cur_wa     <= pend_wa;
                        cur_lane   <= pend_lane;
                        pend_valid <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end else begin
                    mem_addr <= cur_wa;
                    mem_req  <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (mem_dok) begin
                        fill_word <= mem_dout;
                        state     <= S_FILL;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: if (mem_dok) begin
                    fill_word <= mem_dout;
                    state     <= S_FILL;
                end
                S_FILL: begin
                    adp_data <= lane_byte(fill_word, cur_lane);
                    if (pend_valid) begin
                        cur_wa     <= pend_wa;
                        cur_lane   <= pend_lane;
                        pend_valid <= 1'b0;
                        state      <= S_LOOKUP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed after the FSM so a capture in the same clk as a pending drain is kept
            if (cap) begin
                if (state == S_IDLE && !req_new) begin
                    cur_wa   <= ba[MEM_AW:1];
                    cur_lane <= ba[0];
                    req_new  <= 1'b1;
                end else begin
                    pend_wa    <= ba[MEM_AW:1];
                    pend_lane  <= ba[0];
                    pend_valid <= 1'b1;
                end
                if ((state == S_REQ || state == S_WAIT) && late_cnt != '1)
                    late_cnt <= late_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jt10_adpcma_rom_server.sv
// Directed self-checking bench for jt10_adpcma_rom_server.
module tb_jt10_adpcma_rom_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen6;
    logic [19:0] adp_addr;
    logic [3:0]  adp_bank;
    logic        adp_roe_n;
    logic [7:0]  adp_data;
    logic [22:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_dok;
    logic [15:0] mem_dout;
    logic [7:0]  late_cnt;

    int checks = 0;
    int errors = 0;

    jt10_adpcma_rom_server #(
        .ENTRIES (6),
        .MEM_AW  (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen6      (cen6),
        .adp_addr  (adp_addr),
        .adp_bank  (adp_bank),
        .adp_roe_n (adp_roe_n),
        .adp_data  (adp_data),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_dok   (mem_dok),
        .mem_dout  (mem_dout),
        .late_cnt  (late_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fetch(input logic [3:0] b, input logic [19:0] a, input logic roe);
        adp_bank  = b;
        adp_addr  = a;
        adp_roe_n = roe;
        cen6      = 1'b1;
        tick();
        cen6      = 1'b0;
        adp_roe_n = 1'b1;
    endtask

    task automatic ack_req(input string tag, input logic [22:0] ea);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'(1));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_reqdrop"}, 32'(mem_req), 32'(0));
    endtask

    task automatic give_dok(input logic [15:0] w);
        mem_dout = w;
        mem_dok  = 1'b1;
        tick();
        mem_dok  = 1'b0;
    endtask

    // Fetch that must miss; returns once the fill has updated adp_data
    task automatic miss_fill(input string tag, input logic [3:0] b, input logic [19:0] a,
                             input logic [22:0] ea, input logic [15:0] w, input logic [7:0] exp);
        fetch(b, a, 1'b0);
        ack_req(tag, ea);
        give_dok(w);
        tick();
        chk({tag, "_data"}, 32'(adp_data), 32'(exp));
    endtask

    task automatic hit_chk(input string tag, input logic [3:0] b, input logic [19:0] a,
                           input logic [7:0] exp);
        fetch(b, a, 1'b0);
        tick();
        tick();
        chk({tag, "_data"}, 32'(adp_data), 32'(exp));
        chk({tag, "_noreq"}, 32'(mem_req), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        cen6 = 1'b0; adp_addr = '0; adp_bank = '0; adp_roe_n = 1'b1;
        mem_ack = 1'b0; mem_dok = 1'b0; mem_dout = '0;
        #2;
        do_reset();
        chk("rst_data", 32'(adp_data), 32'(0));
        chk("rst_req",  32'(mem_req),  32'(0));
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_late", 32'(late_cnt), 32'(0));

        // 1: cold miss then hit on the other lane
        fetch(4'h0, 20'h00010, 1'b0);
        tick();
        tick();
        chk("t1_req_lat", 32'(mem_req), 32'(1));
        ack_req("t1", 23'h000008);
        give_dok(16'hBEEF);
        tick();
        chk("t1_data", 32'(adp_data), 32'(8'hEF));
        hit_chk("t1_hit", 4'h0, 20'h00011, 8'hBE);

        // 2: bank bits and high lane
        miss_fill("t2", 4'h3, 20'hFFFFF, 23'h1FFFFF, 16'h12AB, 8'h12);

        // 3: round-robin replacement
        do_reset();
        for (int k = 1; k <= 7; k++)
            miss_fill("t3_fill", 4'h0, 20'(k * 256), 23'(k * 128), {8'(k), 8'(k + 16)}, 8'(k + 16));
        hit_chk("t3_w2", 4'h0, 20'h00200, 8'h12);
        hit_chk("t3_w7", 4'h0, 20'h00701, 8'h07);
        fetch(4'h0, 20'h00100, 1'b0);
        tick();
        tick();
        chk("t3_w1_miss", 32'(mem_req), 32'(1));
        ack_req("t3_w1", 23'h000080);
        give_dok(16'h0111);
        tick();
        chk("t3_w1_data", 32'(adp_data), 32'(8'h11));

        // 4: late slots, pending served from fill data, saturation
        do_reset();
        miss_fill("t4_pre", 4'h0, 20'h03000, 23'h001800, 16'h55AA, 8'hAA);
        fetch(4'h1, 20'h02000, 1'b0);
        ack_req("t4", 23'h081000);
        for (int i = 0; i < 3; i++) begin
            repeat (5) tick();
            fetch(4'h1, 20'h02001, 1'b0);
        end
        chk("t4_late3", 32'(late_cnt), 32'(3));
        chk("t4_hold",  32'(adp_data), 32'(8'hAA));
        repeat (2) tick();
        give_dok(16'h1234);
        tick();
        chk("t4_fill", 32'(adp_data), 32'(8'h34));
        tick();
        chk("t4_pend", 32'(adp_data), 32'(8'h12));
        chk("t4_pend_noreq", 32'(mem_req), 32'(0));
        fetch(4'h2, 20'h00100, 1'b0);
        ack_req("t4s", 23'h100080);
        for (int i = 0; i < 300; i++)
            fetch(4'h2, 20'h00101, 1'b0);
        chk("t4_sat", 32'(late_cnt), 32'(255));
        give_dok(16'hCAFE);
        tick();
        chk("t4s_fill", 32'(adp_data), 32'(8'hFE));
        tick();
        chk("t4s_pend", 32'(adp_data), 32'(8'hCA));
        chk("t4_sat_hold", 32'(late_cnt), 32'(255));

        // 5: reset while a request is outstanding
        miss_fill("t5_pre", 4'h0, 20'h00400, 23'h000200, 16'hC0C1, 8'hC1);
        fetch(4'h0, 20'h00600, 1'b0);
        seen = 0;
        while (!mem_req && seen < 20) begin
            tick();
            seen++;
        end
        chk("t5_req_up", 32'(mem_req), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_req_drop", 32'(mem_req),  32'(0));
        chk("t5_late_clr", 32'(late_cnt), 32'(0));
        chk("t5_data_clr", 32'(adp_data), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_dok = 1'b1;
        mem_dout = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        mem_dok = 1'b0;
        tick();
        chk("t5_stray_req",  32'(mem_req),  32'(0));
        chk("t5_stray_data", 32'(adp_data), 32'(0));
        fetch(4'h0, 20'h00400, 1'b0);
        tick();
        tick();
        chk("t5_refetch_miss", 32'(mem_req), 32'(1));
        ack_req("t5b", 23'h000200);
        give_dok(16'hC0C1);
        tick();
        chk("t5b_data", 32'(adp_data), 32'(8'hC1));

        // 6: roe_n high, no traffic
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            fetch(4'h5, 20'(i * 2), 1'b1);
            repeat (5) begin
                tick();
                if (mem_req) seen = 1;
            end
        end
        chk("t6_noreq",  32'(seen),     32'(0));
        chk("t6_stable", 32'(adp_data), 32'(8'hC1));
        chk("t6_late",   32'(late_cnt), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
